token_slice_parser: RTL and testbench

- Second-level parser of the Snappy decompressor.
- Pops 18-byte slices from the token queue, which holds first-level preparser output.
- Decodes every Snappy tag header flagged in the slice's position bitmap.
- Emits one decoded literal/copy command per cycle to the command dispatcher, with valid/ready flow control.

---
 rtl/snappy_pkg.sv | 39 +++
 rtl/token_slice_parser_if.sv | 32 +++
 rtl/token_slice_parser_lowest_bit_enc.sv | 17 +
 rtl/token_slice_parser.sv | 139 +++++++++++++
 tb/tb_token_slice_parser.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/snappy_pkg.sv
// Shared Snappy decompressor types: tag codes, slice geometry and the decoded command.
// Included by the token-slice parser, its interface and the bench-facing top.
package snappy_pkg;

    localparam int SLICE_BYTES = 18;
    localparam int POS_BITS    = 16;
    localparam int ADDR_W      = 17;
    localparam int DATA_W      = SLICE_BYTES * 8;
    localparam int LEN_W       = 17;
    localparam int OFF_W       = 16;

    localparam logic [1:0] LIT = 2'b00;
    localparam logic [1:0] CP1 = 2'b01;
    localparam logic [1:0] CP2 = 2'b10;
    localparam logic [1:0] CP4 = 2'b11;

    // Literal length codes at and above 60 carry the length in trailing bytes.
    localparam logic [5:0] LIT_EXT1 = 6'd60;
    localparam logic [5:0] LIT_EXT2 = 6'd61;
    localparam logic [5:0] LIT_EXT3 = 6'd62;
    localparam logic [5:0] LIT_EXT4 = 6'd63;

    typedef struct packed {
        logic              is_copy;
        logic [LEN_W-1:0]  len;
        logic [OFF_W-1:0]  offset;
        logic [ADDR_W-1:0] addr;
        logic              lit_slice;
    } token_t;

    // Byte 0 sits in the most significant lane of the slice.
    function automatic logic [7:0] slice_byte(input logic [DATA_W-1:0] data,
                                              input logic [4:0]        idx);
        logic [DATA_W-1:0] w_sh;
        w_sh = data << (8 * idx);
        return w_sh[DATA_W-1 -: 8];
    endfunction

endpackage

// File: rtl/token_slice_parser_if.sv
// Token-queue pop side and command-dispatch side of the slice parser.
// master = parser, slave = queue/dispatcher environment.
interface token_slice_parser_if;
    import snappy_pkg::*;

    logic [DATA_W-1:0]   data_in;
    logic [POS_BITS-1:0] position_in;
    logic [ADDR_W-1:0]   address_in;
    logic [2:0]          garbage_in;
    logic                lit_flag_in;
    logic                valid_in;
    logic                rdreq;
    logic                tok_valid;
    logic                tok_ready;
    logic                tok_is_copy;
    logic [LEN_W-1:0]    tok_len;
    logic [OFF_W-1:0]    tok_offset;
    logic [ADDR_W-1:0]   tok_addr;
    logic                tok_lit_slice;
    logic                err;

    modport master (
        input  data_in, position_in, address_in, garbage_in, lit_flag_in, valid_in, tok_ready,
        output rdreq, tok_valid, tok_is_copy, tok_len, tok_offset, tok_addr, tok_lit_slice, err
    );

    modport slave (
        output data_in, position_in, address_in, garbage_in, lit_flag_in, valid_in, tok_ready,
        input  rdreq, tok_valid, tok_is_copy, tok_len, tok_offset, tok_addr, tok_lit_slice, err
    );

endinterface

// File: rtl/token_slice_parser_lowest_bit_enc.sv
// Combinational priority encoder: index of the lowest set bit of a 16-bit mask.
// o_any is low when the mask is empty (o_idx is then 0).
module lowest_bit_enc (
    input  logic [15:0] i_mask,
    output logic [3:0]  o_idx,
    output logic        o_any
);

    always_comb begin
        o_idx = '0;
        o_any = |i_mask;
        for (int i = 15; i >= 0; i--) begin
            if (i_mask[i]) o_idx = 4'(i);
        end
    end

endmodule

// File: rtl/token_slice_parser.sv
// Snappy second-level parser: pops 18-byte slices, emits one decoded literal/copy per cycle.
// Slice-to-first-token latency 2 cycles; a stalled output register stalls the scan and the pop.
module token_slice_parser
    import snappy_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    token_slice_parser_if.master bus
);

    typedef enum logic {HOLD_EMPTY, SCAN} state_t;

    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_data;
    logic [POS_BITS-1:0] r_mask;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_lit;
    token_t              r_tok;
    logic                r_tok_vld;
    logic                r_err;

    logic [3:0]          w_idx;
    logic                w_any;
    logic                w_out_free;
    logic                w_take;
    logic                w_rdreq;
    logic                w_supported;
    logic [POS_BITS-1:0] w_mask_clr;
    logic [POS_BITS-1:0] w_cap_mask;
    logic [7:0]          w_tag, w_b1, w_b2;
    logic [5:0]          w_code;
    token_t              w_tok;

    lowest_bit_enc u_lsb (
        .i_mask (r_mask),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    assign w_out_free = !r_tok_vld || bus.tok_ready;
    assign w_mask_clr = r_mask & ~(16'(1) << w_idx);
    assign w_cap_mask = bus.position_in & ~((16'(1) << bus.garbage_in) - 16'(1));
    assign w_tag      = slice_byte(r_data, {1'b0, w_idx});
    assign w_b1       = slice_byte(r_data, {1'b0, w_idx} + 5'd1);
    assign w_b2       = slice_byte(r_data, {1'b0, w_idx} + 5'd2);
    assign w_code     = w_tag[7:2];

    always_comb begin
        w_tok           = '0;
        w_supported     = 1'b1;
        w_tok.addr      = r_addr + ADDR_W'(w_idx);
        w_tok.lit_slice = r_lit;
        case (w_tag[1:0])
            LIT: begin
                if (w_code < LIT_EXT1)       w_tok.len = LEN_W'(w_code) + 17'd1;
                else if (w_code == LIT_EXT1) w_tok.len = LEN_W'(w_b1) + 17'd1;
                else if (w_code == LIT_EXT2) w_tok.len = LEN_W'({w_b2, w_b1}) + 17'd1;
                else                         w_supported = 1'b0;
            end
            CP1: begin
                w_tok.is_copy = 1'b1;
                w_tok.len     = LEN_W'(w_tag[4:2]) + 17'd4;
                w_tok.offset  = {5'd0, w_tag[7:5], w_b1};
            end
            CP2: begin
                w_tok.is_copy = 1'b1;
                w_tok.len     = LEN_W'(w_code) + 17'd1;
                w_tok.offset  = {w_b2, w_b1};
            end
            default: w_supported = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= HOLD_EMPTY;
        else     r_state <= w_state_nxt;
    end

    // A slice retires in the cycle its last header is taken; the next one may pop in that same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_rdreq     = 1'b0;
        w_take      = 1'b0;
        case (r_state)
            HOLD_EMPTY: begin
                if (bus.valid_in) begin
                    w_rdreq     = 1'b1;
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                w_take = w_any && w_out_free;
                if (!w_any || (w_take && w_mask_clr == '0)) begin
                    if (bus.valid_in) w_rdreq     = 1'b1;
                    else              w_state_nxt = HOLD_EMPTY;
                end
            end
            default: w_state_nxt = HOLD_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_mask    <= '0;
            r_addr    <= '0;
            r_lit     <= 1'b0;
            r_tok     <= '0;
            r_tok_vld <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_rdreq) begin
                r_data <= bus.data_in;
                r_mask <= w_cap_mask;
                r_addr <= bus.address_in;
                r_lit  <= bus.lit_flag_in;
            end else if (w_take) begin
                r_mask <= w_mask_clr;
            end
            if (w_take && w_supported) begin
                r_tok     <= w_tok;
                r_tok_vld <= 1'b1;
            end else if (bus.tok_ready) begin
                r_tok_vld <= 1'b0;
            end
            if (w_take && !w_supported) r_err <= 1'b1;
        end
    end

    assign bus.rdreq         = w_rdreq && !rst;
    assign bus.tok_valid     = r_tok_vld;
    assign bus.tok_is_copy   = r_tok.is_copy;
    assign bus.tok_len       = r_tok.len;
    assign bus.tok_offset    = r_tok.offset;
    assign bus.tok_addr      = r_tok.addr;
    assign bus.tok_lit_slice = r_tok.lit_slice;
    assign bus.err           = r_err;

endmodule

// File: tb/tb_token_slice_parser.sv
// Bench for token_slice_parser: show-ahead queue model driving slices, arithmetic reference decoder.
module tb_token_slice_parser;

    typedef struct {
        logic [143:0] data;
        logic [15:0]  pos;
        logic [16:0]  addr;
        logic [2:0]   garb;
        logic         lit;
    } slice_t;

    typedef struct {
        int is_copy;
        int len;
        int offset;
        int addr;
        int lit;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    token_slice_parser_if bus();

    token_slice_parser dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    slice_t sq[$];
    exp_t   eq[$];
    int     pop_cyc[$];
    int     n_chk = 0;
    int     n_err = 0;
    bit     exp_err = 0;
    int     lat_vin, lat_tv, stall_pops;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int get_b(input slice_t s, input int i);
        return int'(s.data[143-8*i -: 8]);
    endfunction

    function automatic logic [143:0] pack(input logic [7:0] b[18]);
        logic [143:0] d;
        for (int i = 0; i < 18; i++) d[143-8*i -: 8] = b[i];
        return d;
    endfunction

    // Reference decode of every surviving header, straight from the tag-format rules.
    task automatic push_slice(input slice_t s);
        int tag, b1, b2, n;
        exp_t e;
        sq.push_back(s);
        for (int p = int'(s.garb); p < 16; p++) begin
            if (!s.pos[p]) continue;
            tag = get_b(s, p); b1 = get_b(s, p + 1); b2 = get_b(s, p + 2);
            n = tag / 4;
            e.addr = (int'(s.addr) + p) % 131072;
            e.lit = int'(s.lit);
            e.offset = 0;
            case (tag % 4)
                0: begin
                    e.is_copy = 0;
                    if (n < 60)       e.len = n + 1;
                    else if (n == 60) e.len = b1 + 1;
                    else if (n == 61) e.len = b2 * 256 + b1 + 1;
                    else begin exp_err = 1; continue; end
                end
                1: begin e.is_copy = 1; e.len = (n % 8) + 4; e.offset = (tag / 32) * 256 + b1; end
                2: begin e.is_copy = 1; e.len = n + 1; e.offset = b2 * 256 + b1; end
                default: begin exp_err = 1; continue; end
            endcase
            eq.push_back(e);
        end
    endtask

    task automatic run_traffic(input int max_cyc, input int stall, input bit rnd_ready,
                               input bit need_done, input bit gap_chk);
        int cyc = 0, last = -1;
        bit done = 0, prev_stall = 0;
        logic [63:0] prev_f = '0, cur_f;
        exp_t e;
        lat_vin = -1; lat_tv = -1; stall_pops = 0;
        pop_cyc.delete();
        while (cyc < max_cyc && !done) begin
            @(posedge clk); #1;
            if (sq.size() > 0) begin
                bus.valid_in = 1'b1;    bus.data_in = sq[0].data;
                bus.position_in = sq[0].pos; bus.address_in = sq[0].addr;
                bus.garbage_in = sq[0].garb; bus.lit_flag_in = sq[0].lit;
            end else begin
                bus.valid_in = 1'b0;    bus.data_in = '0;
                bus.position_in = '0;   bus.address_in = '0;
                bus.garbage_in = '0;    bus.lit_flag_in = 1'b0;
            end
            bus.tok_ready = (cyc < stall) ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            if (bus.valid_in && lat_vin < 0) lat_vin = cyc;
            @(negedge clk);
            if (bus.tok_valid && lat_tv < 0) lat_tv = cyc;
            cur_f = {12'd0, bus.tok_is_copy, bus.tok_len, bus.tok_offset, bus.tok_addr, bus.tok_lit_slice};
            if (prev_stall) begin
                chk("hold_valid", 64'(bus.tok_valid), 64'd1);
                chk("hold_fields", cur_f, prev_f);
            end
            prev_stall = bus.tok_valid && !bus.tok_ready;
            prev_f = cur_f;
            if (bus.rdreq) begin
                chk("rdreq_needs_valid", 64'(bus.valid_in), 64'd1);
                pop_cyc.push_back(cyc);
                if (cyc > 0 && cyc < stall) stall_pops++;
                if (sq.size() > 0) void'(sq.pop_front());
            end
            if (bus.tok_valid && bus.tok_ready) begin
                if (eq.size() == 0) begin
                    chk("extra_token", 64'd1, 64'd0);
                end else begin
                    e = eq.pop_front();
                    chk("is_copy", 64'(bus.tok_is_copy), 64'(e.is_copy));
                    chk("len", 64'(bus.tok_len), 64'(e.len));
                    chk("offset", 64'(bus.tok_offset), 64'(e.offset));
                    chk("addr", 64'(bus.tok_addr), 64'(e.addr));
                    chk("lit_slice", 64'(bus.tok_lit_slice), 64'(e.lit));
                end
                if (gap_chk && last >= 0) chk("no_gap", 64'(cyc - last), 64'd1);
                last = cyc;
            end
            cyc++;
            done = (sq.size() == 0) && (eq.size() == 0);
        end
        if (need_done) chk("completed_in_budget", 64'(done), 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rdreq"}, 64'(bus.rdreq), 64'd0);
        chk({tag, "_tok_valid"}, 64'(bus.tok_valid), 64'd0);
        chk({tag, "_err"}, 64'(bus.err), 64'd0);
        chk({tag, "_fields"}, {12'd0, bus.tok_is_copy, bus.tok_len, bus.tok_offset,
                               bus.tok_addr, bus.tok_lit_slice}, 64'd0);
    endtask

    function automatic slice_t mk(input logic [15:0] pos, input logic [16:0] addr,
                                  input logic [2:0] garb, input logic lit, input logic [7:0] b[18]);
        slice_t s;
        s.data = pack(b); s.pos = pos; s.addr = addr; s.garb = garb; s.lit = lit;
        return s;
    endfunction

    initial begin
        logic [7:0] b[18];
        slice_t s;

        bus.valid_in = 1'b1; bus.tok_ready = 1'b1; bus.data_in = '1;
        bus.position_in = '1; bus.address_in = '0; bus.garbage_in = '0; bus.lit_flag_in = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;
        bus.valid_in = 1'b0;

        // Short literal with latency and single-pop check.
        foreach (b[i]) b[i] = 8'h00;
        b[0] = 8'h0C;
        push_slice(mk(16'h0001, 17'h00100, 3'd0, 1'b0, b));
        run_traffic(50, 0, 0, 1, 0);
        chk("latency", 64'(lat_tv - lat_vin), 64'd2);
        chk("pop_count_t1", 64'(pop_cyc.size()), 64'd1);

        // Copy1 then copy2 in one slice.
        foreach (b[i]) b[i] = 8'h00;
        b[0] = 8'h2D; b[1] = 8'h10; b[4] = 8'h0E; b[5] = 8'h34; b[6] = 8'h12;
        push_slice(mk(16'h0011, 17'h1FFFE, 3'd0, 1'b1, b));
        run_traffic(50, 0, 0, 1, 1);

        // Garbage masks headers 0 and 1.
        foreach (b[i]) b[i] = 8'h04;
        b[2] = 8'h08;
        push_slice(mk(16'h0007, 17'h00040, 3'd2, 1'b0, b));
        run_traffic(50, 0, 0, 1, 0);

        // Two-byte literal length at p=15 reaching 65536.
        foreach (b[i]) b[i] = 8'h00;
        b[15] = 8'hF4; b[16] = 8'hFF; b[17] = 8'hFF;
        push_slice(mk(16'h8000, 17'h00200, 3'd0, 1'b0, b));
        run_traffic(50, 0, 0, 1, 0);

        // Backpressure: three headers held under a 5-cycle stall, then a second slice with no gap.
        foreach (b[i]) b[i] = 8'h00;
        b[0] = 8'h08; b[4] = 8'h0C; b[8] = 8'h10;
        push_slice(mk(16'h0111, 17'h00300, 3'd0, 1'b0, b));
        foreach (b[i]) b[i] = 8'h00;
        b[0] = 8'h14;
        push_slice(mk(16'h0001, 17'h00400, 3'd0, 1'b1, b));
        run_traffic(60, 5, 0, 1, 1);
        chk("no_pop_during_stall", 64'(stall_pops), 64'd0);
        chk("pop_count_t5", 64'(pop_cyc.size()), 64'd2);

        // Empty-mask slice retires one cycle after capture.
        foreach (b[i]) b[i] = 8'h00;
        push_slice(mk(16'h0000, 17'h00500, 3'd0, 1'b1, b));
        b[3] = 8'h18;
        push_slice(mk(16'h0008, 17'h00600, 3'd0, 1'b0, b));
        run_traffic(50, 0, 0, 1, 0);
        chk("empty_slice_pops", 64'(pop_cyc.size()), 64'd2);
        if (pop_cyc.size() == 2) chk("empty_slice_retire", 64'(pop_cyc[1] - pop_cyc[0]), 64'd1);
        chk("err_clean", 64'(bus.err), 64'(exp_err));

        // Unsupported copy4 and literal-62 tags are dropped; the valid token between them survives.
        foreach (b[i]) b[i] = 8'h00;
        b[0] = 8'h03; b[1] = 8'h00; b[4] = 8'hF8;
        push_slice(mk(16'h0013, 17'h00700, 3'd0, 1'b0, b));
        run_traffic(50, 0, 0, 1, 0);
        chk("err_set", 64'(bus.err), 64'd1);

        // Reset mid-slice discards the slice and the held token and clears err.
        foreach (b[i]) b[i] = 8'h00;
        push_slice(mk(16'h0111, 17'h00800, 3'd0, 1'b0, b));
        run_traffic(4, 100, 0, 0, 0);
        chk("pre_reset_tok_valid", 64'(bus.tok_valid), 64'd1);
        @(posedge clk); #1 rst = 1'b1; bus.valid_in = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        sq.delete(); eq.delete(); exp_err = 0;
        @(posedge clk); #1 rst = 1'b0; bus.valid_in = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Randomized slices with random backpressure; tags sanitized to supported encodings.
        for (int n = 0; n < 40; n++) begin
            foreach (b[i]) b[i] = 8'($urandom);
            s.pos = 16'($urandom);
            if (n % 8 == 0) s.pos = '0;
            for (int p = 0; p < 16; p++) begin
                if (s.pos[p]) begin
                    if (b[p][1:0] == 2'b11) b[p][0] = 1'b0;
                    if (b[p][1:0] == 2'b00 && b[p][7:2] >= 6'd62) b[p][3] = 1'b0;
                end
            end
            push_slice(mk(s.pos, 17'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), b));
        end
        run_traffic(3000, 0, 1, 1, 0);
        chk("err_random", 64'(bus.err), 64'(exp_err));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
